axi3_to_inter: RTL and testbench
================================

AXI3_TO_INTER -- requirements
Module: axi3_to_inter

Interface
REQ-001 Parameter ID_W, default 12: AXI ID width for AWID, BID, ARID and RID.
REQ-002 Parameter RD_TIMEOUT, default 16: maximum number of cycles to wait for bus_rvalid.
REQ-003 aclk  in  1  single clock for the AXI side and the internal bus.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 AXI3 write-address inputs: awid[ID_W], awaddr[32], awlen[4], awsize[3], awburst[2], awvalid; output awready.
REQ-006 AXI3 write-data inputs: wdata[32], wstrb[4], wlast, wvalid; output wready.
REQ-007 AXI3 write-response outputs: bid[ID_W], bresp[2], bvalid; input bready.
REQ-008 AXI3 read-address inputs: arid[ID_W], araddr[32], arlen[4], arsize[3], arburst[2], arvalid; output arready.
REQ-009 AXI3 read-data outputs: rid[ID_W], rdata[32], rresp[2], rlast, rvalid; input rready.
REQ-010 Internal-bus outputs: bus_addr[30] (word address), bus_wdata[32], bus_wr (1-cycle strobe), bus_rd (1-cycle strobe).
REQ-011 Internal-bus inputs: bus_rdata[32] and bus_rvalid (1-cycle, arrives any number of cycles after bus_rd).

Function
REQ-012 The bridge SHALL process one transaction at a time, using FSM states IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT and RD_DATA.
REQ-013 In IDLE, awready and arready SHALL be high; a handshake moves the FSM to WR_DATA or RD_REQ.
REQ-014 If awvalid and arvalid are both high in the same cycle, the write SHALL win; arready is low in that cycle.
REQ-015 On address handshake the bridge SHALL latch: ID, address[31:2] as the word address, len+1 as the beat count, and burst type.
REQ-016 Address per beat: FIXED keeps the same address; INCR and WRAP both add +1 word per beat; the 30-bit address wraps modulo 2^30.
REQ-017 awsize and arsize are ignored; every beat is 32 bits.
REQ-018 WR_DATA: wready is high; each W handshake drives bus_wr=1 in that same cycle, with bus_wdata=wdata and bus_addr set to the current beat address.
REQ-019 wstrb is ignored: a full-word write is performed even with a partial strobe.
REQ-020 WR_DATA exit: after the final beat (wlast, or beat count reached, whichever comes first) the FSM moves to WR_RESP.
REQ-021 WR_RESP: bvalid=1, bid=latched AWID, bresp=OKAY (00); hold until bready, then return to IDLE.
REQ-022 RD_REQ: drive bus_rd=1 for one cycle with the beat address, then move to RD_WAIT.
REQ-023 RD_WAIT: on bus_rvalid, capture bus_rdata and move to RD_DATA.
REQ-024 RD_WAIT timeout: if RD_TIMEOUT cycles pass without bus_rvalid, capture rdata=0 with rresp=SLVERR (10) and move to RD_DATA.
REQ-025 RD_DATA: rvalid=1, rid=latched ARID, rlast on the final beat; rdata and rresp are held stable until rready.
REQ-026 RD_DATA exit: on the rready handshake, go to the next beat's RD_REQ, or to IDLE after the last beat.
REQ-027 All AXI outputs SHALL be registered; bus_wr and bus_rd are asserted for exactly one cycle per beat.

Reset
REQ-028 On resetn low, the FSM SHALL go to IDLE; all valid, ready and strobe outputs go to 0 except awready and arready, which go to 1 one cycle after reset release; data and ID registers go to 0.
REQ-029 Reset mid-burst SHALL abort the transaction silently, with no response issued.

Structure
REQ-030 Package axi3_pkg SHALL hold the RESP codes (OKAY=00, SLVERR=10), the BURST codes (FIXED=00, INCR=01, WRAP=10), the data/address widths and the FSM state enum.
REQ-031 The axi3_interface bundle SHALL carry the AXI3 signals with aclk and resetn; the bridge connects to it through a slave modport.
REQ-032 No sub-module is required; the read-timeout counter stays inline.
REQ-033 The cpu_sim master BFM is bench-only (non-synthesizable); it drives the axi3_interface from aclk and resetn.

Verification
REQ-034 Single write: AW addr 0x40000004, len 0, wdata 0x12345678 -> one bus_wr pulse with bus_addr=0x10000001 and data 0x12345678; then bvalid with bresp=00 and the matching bid.
REQ-035 Single read: AR addr 0x40000008; bus returns 0xCAFEBABE after 3 cycles -> rdata=0xCAFEBABE, rresp=00, rlast=1.
REQ-036 INCR read burst: araddr 0x40000010, arlen 3 -> bus_rd at word addresses 0x10000004 to 0x10000007, four R beats, rlast only on the 4th; stall rready for 5 cycles on beat 2 with rdata held.
REQ-037 Simultaneous awvalid and arvalid -> the write completes first (bvalid seen before any bus_rd), then the read is served.
REQ-038 No bus_rvalid for 16 cycles -> rresp=SLVERR, rdata=0; the next transaction proceeds normally.
REQ-039 Reset asserted during the 2nd beat of a 4-beat write -> no bvalid; the FSM returns to IDLE, and a following single write succeeds.

Source files
------------

// File: rtl/axi3_pkg.sv
// Shared types and constants for the AXI3 to internal-bus bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi3_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int WADDR_W = 30;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_REQ,
        RD_WAIT,
        RD_DATA
    } state_t;

    // FIXED repeats the word address; INCR and WRAP both step one word and
    // roll over naturally at 2^30.
    function automatic logic [WADDR_W-1:0] next_addr(input logic [WADDR_W-1:0] addr,
                                                     input logic [1:0]         burst);
        return (burst == BURST_FIXED) ? addr : addr + WADDR_W'(1);
    endfunction

endpackage

// File: rtl/axi3_if.sv
// AXI3 signal bundle shared by the bridge (slave) and a bench master.
// Latency: n/a (wiring only).
// Backpressure: carries the standard valid/ready pairs of each channel.
interface axi3_interface #(
    parameter int ID_W = 12
) (
    input logic aclk,
    input logic resetn
);
    import axi3_pkg::*;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  aclk, resetn,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        input  aclk, resetn,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/axi3_to_inter.sv
// AXI3 slave to single-word internal bus bridge, one transaction at a time.
// Latency: bus_wr in the W handshake cycle; bus_rd one cycle after AR/R handshake, R beat one cycle after bus_rvalid.
// Backpressure: wready/awready/arready held low outside their states; R and B held until rready/bready.
module axi3_to_inter
    import axi3_pkg::*;
#(
    parameter int ID_W       = 12,
    parameter int RD_TIMEOUT = 16
) (
    input  logic               aclk,
    input  logic               resetn,
    axi3_interface.slave       axi,
    output logic [WADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0]  bus_wdata,
    output logic               bus_wr,
    output logic               bus_rd,
    input  logic [DATA_W-1:0]  bus_rdata,
    input  logic               bus_rvalid
);

    localparam int TMO_W = $clog2(RD_TIMEOUT + 1);

    state_t              state;
    logic [ID_W-1:0]     id_q;
    logic [WADDR_W-1:0]  addr_q;
    logic [4:0]          beats_left;
    logic [1:0]          burst_q;
    logic [TMO_W-1:0]    tmo_cnt;

    logic                awready_q, arready_q, wready_q;
    logic                bvalid_q, rvalid_q, rlast_q;
    logic [ID_W-1:0]     bid_q, rid_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                aw_hs, ar_hs, last_beat;

    // Size, strobe and byte-offset bits are accepted but do not change behaviour.
    logic                unused_ok;
    assign unused_ok = ^{axi.awsize, axi.arsize, axi.wstrb, axi.awaddr[1:0],
                         axi.araddr[1:0], axi.aclk, axi.resetn};

    // A simultaneous write request must win, so arready is masked by awvalid
    // in that very cycle; a registered-only ready could not do that.
    assign aw_hs     = axi.awvalid && awready_q;
    assign ar_hs     = axi.arvalid && arready_q && !axi.awvalid;
    assign last_beat = (beats_left == 5'd1);

    assign axi.awready = awready_q;
    assign axi.arready = arready_q && !axi.awvalid;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bid     = bid_q;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rid     = rid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;

    // Writes go out in the W handshake cycle; reads strobe once per RD_REQ visit.
    assign bus_addr  = addr_q;
    assign bus_wr    = (state == WR_DATA) && axi.wvalid;
    assign bus_wdata = bus_wr ? axi.wdata : '0;
    assign bus_rd    = (state == RD_REQ);

    // Transaction FSM with all AXI-side outputs held in registers.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            beats_left <= '0;
            burst_q    <= '0;
            tmo_cnt    <= '0;
            awready_q  <= 1'b0;
            arready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    awready_q <= 1'b1;
                    arready_q <= 1'b1;
                    if (aw_hs) begin
                        state      <= WR_DATA;
                        awready_q  <= 1'b0;
                        arready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        id_q       <= axi.awid;
                        addr_q     <= axi.awaddr[ADDR_W-1:2];
                        beats_left <= {1'b0, axi.awlen} + 5'd1;
                        burst_q    <= axi.awburst;
                    end else if (ar_hs) begin
                        state      <= RD_REQ;
                        awready_q  <= 1'b0;
                        arready_q  <= 1'b0;
                        id_q       <= axi.arid;
                        addr_q     <= axi.araddr[ADDR_W-1:2];
                        beats_left <= {1'b0, axi.arlen} + 5'd1;
                        burst_q    <= axi.arburst;
                    end
                end
                WR_DATA: begin
                    if (axi.wvalid) begin
                        addr_q     <= next_addr(addr_q, burst_q);
                        beats_left <= beats_left - 5'd1;
                        if (axi.wlast || last_beat) begin
                            state    <= WR_RESP;
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= RESP_OKAY;
                        end
                    end
                end
                WR_RESP: begin
                    if (axi.bready) begin
                        state     <= IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        arready_q <= 1'b1;
                    end
                end
                RD_REQ: begin
                    state   <= RD_WAIT;
                    tmo_cnt <= '0;
                end
                RD_WAIT: begin
                    if (bus_rvalid) begin
                        state    <= RD_DATA;
                        rvalid_q <= 1'b1;
                        rid_q    <= id_q;
                        rdata_q  <= bus_rdata;
                        rresp_q  <= RESP_OKAY;
                        rlast_q  <= last_beat;
                    end else if (tmo_cnt == TMO_W'(RD_TIMEOUT - 1)) begin
                        state    <= RD_DATA;
                        rvalid_q <= 1'b1;
                        rid_q    <= id_q;
                        rdata_q  <= '0;
                        rresp_q  <= RESP_SLVERR;
                        rlast_q  <= last_beat;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                RD_DATA: begin
                    if (axi.rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (last_beat) begin
                            state     <= IDLE;
                            awready_q <= 1'b1;
                            arready_q <= 1'b1;
                        end else begin
                            state      <= RD_REQ;
                            addr_q     <= next_addr(addr_q, burst_q);
                            beats_left <= beats_left - 5'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi3_to_inter.sv
// Directed bench: cpu_sim-style AXI3 master tasks plus a bus responder/monitor.
// Latency: n/a.
// Backpressure: master stalls rready on demand; responder delay is programmable.
module tb_axi3_to_inter;
    import axi3_pkg::*;

    localparam int ID_W = 12;

    logic aclk = 1'b0;
    logic resetn = 1'b0;
    always #5 aclk = ~aclk;

    axi3_interface #(.ID_W(ID_W)) axi (.aclk(aclk), .resetn(resetn));

    logic [WADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0]  bus_wdata;
    logic               bus_wr, bus_rd;
    logic [DATA_W-1:0]  bus_rdata;
    logic               bus_rvalid;

    axi3_to_inter #(.ID_W(ID_W), .RD_TIMEOUT(16)) dut (
        .aclk       (aclk),
        .resetn     (resetn),
        .axi        (axi),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wr     (bus_wr),
        .bus_rd     (bus_rd),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [29:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [29:0] rd_addr_q[$];
    logic [31:0] rsp_q[$];
    int          rsp_delay = 3;
    int          pend = -1;
    bit          b_seen = 0;
    bit          rd_before_b = 0;
    logic [3:0]  wstrb_val = 4'hF;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus-side monitor and read responder, evaluated mid-cycle.
    always @(negedge aclk) begin
        if (bus_wr) begin
            wr_addr_q.push_back(bus_addr);
            wr_data_q.push_back(bus_wdata);
        end
        if (axi.bvalid) b_seen = 1;
        bus_rvalid = 1'b0;
        if (pend == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'hDEAD_BEEF;
            pend = -1;
        end else if (pend > 0) begin
            pend--;
        end
        if (bus_rd) begin
            rd_addr_q.push_back(bus_addr);
            if (!b_seen) rd_before_b = 1;
            if (rsp_delay >= 1) pend = rsp_delay - 1;
        end
    end

    // All master tasks start and end at posedge+1.
    task automatic aw_send(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        bit hs = 0;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awsize = 3'd2;
        axi.awburst = burst; axi.awvalid = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge aclk); hs = axi.awready;
            @(posedge aclk); #1;
        end
        axi.awvalid = 1'b0;
        check("aw_handshake", 64'(hs), 64'd1);
    endtask

    task automatic ar_send(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
        bit hs = 0;
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arsize = 3'd2;
        axi.arburst = burst; axi.arvalid = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge aclk); hs = axi.arready;
            @(posedge aclk); #1;
        end
        axi.arvalid = 1'b0;
        check("ar_handshake", 64'(hs), 64'd1);
    endtask

    task automatic w_beat(input logic [31:0] data, input logic last);
        bit hs = 0;
        axi.wdata = data; axi.wstrb = wstrb_val; axi.wlast = last; axi.wvalid = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge aclk); hs = axi.wready;
            @(posedge aclk); #1;
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        check("w_handshake", 64'(hs), 64'd1);
    endtask

    task automatic b_recv(input logic [ID_W-1:0] exp_id);
        bit got = 0;
        logic [ID_W-1:0] id_s = '0;
        logic [1:0] resp_s = 2'b11;
        axi.bready = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk); got = axi.bvalid; id_s = axi.bid; resp_s = axi.bresp;
            @(posedge aclk); #1;
        end
        axi.bready = 1'b0;
        check("bvalid", 64'(got), 64'd1);
        check("bid", 64'(id_s), 64'(exp_id));
        check("bresp", 64'(resp_s), 64'(RESP_OKAY));
    endtask

    task automatic r_recv(input string tag, input logic [ID_W-1:0] exp_id,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp,
                          input logic exp_last, input int stall);
        bit got = 0;
        axi.rready = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge aclk); got = axi.rvalid;
            if (!got) begin @(posedge aclk); #1; end
        end
        check({tag, "_rvalid"}, 64'(got), 64'd1);
        if (got) begin
            check({tag, "_rdata"}, 64'(axi.rdata), 64'(exp_data));
            check({tag, "_rresp"}, 64'(axi.rresp), 64'(exp_resp));
            check({tag, "_rlast"}, 64'(axi.rlast), 64'(exp_last));
            check({tag, "_rid"},   64'(axi.rid),   64'(exp_id));
            for (int s = 0; s < stall; s++) begin
                @(negedge aclk);
                check({tag, "_hold"}, {31'd0, axi.rvalid, axi.rdata}, {31'd0, 1'b1, exp_data});
            end
            @(posedge aclk); #1; axi.rready = 1'b1;
            @(posedge aclk); #1; axi.rready = 1'b0;
        end
    endtask

    task automatic axi_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [1:0] burst,
                             input logic [31:0] base, input int nbeats);
        aw_send(id, addr, len, burst);
        for (int i = 0; i < nbeats; i++) w_beat(base + 32'(i), i == nbeats - 1);
        b_recv(id);
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bcnt;
        bus_rvalid = 1'b0; bus_rdata = '0;
        axi.awvalid = 0; axi.wvalid = 0; axi.bready = 0; axi.arvalid = 0; axi.rready = 0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.wdata = '0; axi.wstrb = '0; axi.wlast = 0;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;

        // Reset values
        repeat (3) @(negedge aclk);
        check("rst_awready", 64'(axi.awready), 64'd0);
        check("rst_arready", 64'(axi.arready), 64'd0);
        check("rst_wready",  64'(axi.wready),  64'd0);
        check("rst_bvalid",  64'(axi.bvalid),  64'd0);
        check("rst_rvalid",  64'(axi.rvalid),  64'd0);
        check("rst_strobes", 64'({bus_wr, bus_rd}), 64'd0);
        check("rst_rdata",   64'(axi.rdata), 64'd0);
        resetn = 1'b1;
        #1 check("rel_awready_0", 64'(axi.awready), 64'd0);
        @(negedge aclk);
        check("rel_awready_1", 64'(axi.awready), 64'd1);
        check("rel_arready_1", 64'(axi.arready), 64'd1);
        @(posedge aclk); #1;

        // Single write
        clear_logs();
        axi_write(12'h0A5, 32'h4000_0004, 4'd0, BURST_INCR, 32'h1234_5678, 1);
        check("sw_count", 64'(wr_addr_q.size()), 64'd1);
        if (wr_addr_q.size() == 1) begin
            check("sw_addr", 64'(wr_addr_q[0]), 64'h1000_0001);
            check("sw_data", 64'(wr_data_q[0]), 64'h1234_5678);
        end

        // Single read, 3-cycle bus latency
        clear_logs();
        rsp_delay = 3; rsp_q.push_back(32'hCAFE_BABE);
        ar_send(12'h3C1, 32'h4000_0008, 4'd0, BURST_INCR);
        r_recv("sr", 12'h3C1, 32'hCAFE_BABE, RESP_OKAY, 1'b1, 0);
        check("sr_rd_count", 64'(rd_addr_q.size()), 64'd1);
        if (rd_addr_q.size() == 1) check("sr_rd_addr", 64'(rd_addr_q[0]), 64'h1000_0002);

        // INCR read burst, rready stall on beat 2
        clear_logs();
        rsp_delay = 2;
        for (int i = 0; i < 4; i++) rsp_q.push_back(32'h1111_0000 + 32'(i));
        ar_send(12'h007, 32'h4000_0010, 4'd3, BURST_INCR);
        for (int i = 0; i < 4; i++)
            r_recv("burst", 12'h007, 32'h1111_0000 + 32'(i), RESP_OKAY, i == 3, (i == 1) ? 5 : 0);
        check("burst_rd_count", 64'(rd_addr_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < rd_addr_q.size(); i++)
            check("burst_rd_addr", 64'(rd_addr_q[i]), 64'h1000_0004 + 64'(i));

        // Simultaneous AW and AR: write first
        clear_logs();
        b_seen = 0; rd_before_b = 0;
        rsp_q.push_back(32'hFEED_F00D);
        fork
            axi_write(12'h111, 32'h0000_0040, 4'd0, BURST_INCR, 32'hAAAA_0001, 1);
            begin
                ar_send(12'h222, 32'h0000_0080, 4'd0, BURST_INCR);
                r_recv("sim", 12'h222, 32'hFEED_F00D, RESP_OKAY, 1'b1, 0);
            end
            begin
                @(negedge aclk);
                check("sim_awready", 64'(axi.awready), 64'd1);
                check("sim_arready", 64'(axi.arready), 64'd0);
            end
        join
        check("sim_order", 64'(rd_before_b), 64'd0);
        check("sim_wr_count", 64'(wr_addr_q.size()), 64'd1);
        if (rd_addr_q.size() > 0) check("sim_rd_addr", 64'(rd_addr_q[0]), 64'h20);

        // Read timeout, then a normal read
        rsp_delay = -1;
        ar_send(12'h0F0, 32'h0000_1000, 4'd0, BURST_INCR);
        r_recv("tmo", 12'h0F0, 32'h0, RESP_SLVERR, 1'b1, 0);
        rsp_delay = 2; rsp_q.push_back(32'h0BAD_C0DE);
        ar_send(12'h0F1, 32'h0000_1004, 4'd0, BURST_INCR);
        r_recv("post_tmo", 12'h0F1, 32'h0BAD_C0DE, RESP_OKAY, 1'b1, 0);

        // FIXED write with partial strobe: full words, same address
        clear_logs();
        wstrb_val = 4'h1;
        axi_write(12'h033, 32'h0000_0100, 4'd1, BURST_FIXED, 32'h5500_0000, 2);
        wstrb_val = 4'hF;
        check("fixed_count", 64'(wr_addr_q.size()), 64'd2);
        for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
            check("fixed_addr", 64'(wr_addr_q[i]), 64'h40);
            check("fixed_data", 64'(wr_data_q[i]), 64'h5500_0000 + 64'(i));
        end

        // Early wlast ends a 4-beat write after 2 beats
        clear_logs();
        axi_write(12'h044, 32'h0000_0200, 4'd3, BURST_INCR, 32'h7700_0000, 2);
        check("early_count", 64'(wr_addr_q.size()), 64'd2);
        if (wr_addr_q.size() == 2) check("early_addr1", 64'(wr_addr_q[1]), 64'h81);

        // WRAP treated as INCR, crossing the 2^30 word boundary
        clear_logs();
        rsp_q.push_back(32'h0000_00A1); rsp_q.push_back(32'h0000_00A2);
        ar_send(12'h055, 32'hFFFF_FFFC, 4'd1, BURST_WRAP);
        r_recv("wrap0", 12'h055, 32'h0000_00A1, RESP_OKAY, 1'b0, 0);
        r_recv("wrap1", 12'h055, 32'h0000_00A2, RESP_OKAY, 1'b1, 0);
        if (rd_addr_q.size() == 2) begin
            check("wrap_addr0", 64'(rd_addr_q[0]), 64'h3FFF_FFFF);
            check("wrap_addr1", 64'(rd_addr_q[1]), 64'h0);
        end else check("wrap_rd_count", 64'(rd_addr_q.size()), 64'd2);

        // Reset during beat 2 of a 4-beat write
        clear_logs();
        b_seen = 0;
        aw_send(12'h066, 32'h0000_3000, 4'd3, BURST_INCR);
        w_beat(32'h9900_0000, 1'b0);
        axi.wdata = 32'h9900_0001; axi.wlast = 1'b0; axi.wvalid = 1'b1;
        #1 resetn = 1'b0;
        #1 check("mid_rst_wready", 64'(axi.wready), 64'd0);
        @(posedge aclk); #1 axi.wvalid = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk) resetn = 1'b1;
        bcnt = 0;
        repeat (6) begin @(negedge aclk); if (axi.bvalid) bcnt++; end
        check("mid_rst_no_b", 64'(bcnt), 64'd0);
        check("mid_rst_awready", 64'(axi.awready), 64'd1);
        check("mid_rst_wr_count", 64'(wr_addr_q.size()), 64'd1);
        @(posedge aclk); #1;
        clear_logs();
        axi_write(12'h077, 32'h0000_2000, 4'd0, BURST_INCR, 32'h600D_0001, 1);
        check("post_rst_count", 64'(wr_addr_q.size()), 64'd1);
        if (wr_addr_q.size() == 1) begin
            check("post_rst_addr", 64'(wr_addr_q[0]), 64'h800);
            check("post_rst_data", 64'(wr_data_q[0]), 64'h600D_0001);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
